// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit.
//   LoadStoreUnitBytes::Type  - access width / signedness of a memory access
//   LoadStoreUnitFuncts::Type - LOAD or STORE
//   LoadStoreUnitFuncts::state_t - FSM states of load_store_unit
//   is_misaligned()  - alignment check of an access against its width
//   lane_extend()    - pick the addressed lane out of a bus word and extend it

package LoadStoreUnitBytes;
    typedef enum logic [2:0] {
        BYTE   = 3'd0,
        HALF   = 3'd1,
        WORD   = 3'd2,
        BYTE_U = 3'd3,
        HALF_U = 3'd4
    } Type;
endpackage

package LoadStoreUnitFuncts;
    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } Type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte accesses can never be misaligned.
    function automatic logic is_misaligned(input LoadStoreUnitBytes::Type b,
                                           input logic [1:0]             a);
        case (b)
            LoadStoreUnitBytes::HALF,
            LoadStoreUnitBytes::HALF_U: is_misaligned = a[0];
            LoadStoreUnitBytes::WORD:   is_misaligned = (a != 2'b00);
            default:                    is_misaligned = 1'b0;
        endcase
    endfunction

    // Halfword lane uses only a[1]; a[0] is known zero for aligned halves.
    function automatic logic [31:0] lane_extend(input LoadStoreUnitBytes::Type b,
                                                input logic [1:0]             a,
                                                input logic [31:0]            word);
        logic [7:0]  b8;
        logic [15:0] h16;
        b8  = word[{a, 3'b000} +: 8];
        h16 = a[1] ? word[31:16] : word[15:0];
        case (b)
            LoadStoreUnitBytes::BYTE:   lane_extend = {{24{b8[7]}}, b8};
            LoadStoreUnitBytes::BYTE_U: lane_extend = {24'd0, b8};
            LoadStoreUnitBytes::HALF:   lane_extend = {{16{h16[15]}}, h16};
            LoadStoreUnitBytes::HALF_U: lane_extend = {16'd0, h16};
            default:                    lane_extend = word;
        endcase
    endfunction
endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   bytes       - access width of the latched request
//   addr_lo     - byte offset within the word
//   wdata       - raw store data
//   mem_rdata   - bus read word
//   wstrb       - byte enables (unmasked; caller gates with write enable)
//   wdata_lanes - store data replicated across all byte lanes
//   load_data   - selected and extended load result
module lsu_align
    import LoadStoreUnitFuncts::*;
(
    input  LoadStoreUnitBytes::Type bytes,
    input  logic [1:0]              addr_lo,
    input  logic [31:0]             wdata,
    input  logic [31:0]             mem_rdata,
    output logic [3:0]              wstrb,
    output logic [31:0]             wdata_lanes,
    output logic [31:0]             load_data
);
    logic is_word;
    logic is_half;

    assign is_word = (bytes == LoadStoreUnitBytes::WORD);
    assign is_half = (bytes == LoadStoreUnitBytes::HALF) ||
                     (bytes == LoadStoreUnitBytes::HALF_U);

    always_comb begin
        if (is_word)
            wstrb = 4'b1111;
        else if (is_half)
            wstrb = 4'b0011 << addr_lo;
        else
            wstrb = 4'b0001 << addr_lo;
    end

    // Replicating the low byte/half into every lane lets the strobes alone
    // pick the destination, so no data shifter is needed.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wdata_lanes[8*gi +: 8] = is_word ? wdata[8*gi +: 8]
                                          : is_half ? wdata[8*(gi%2) +: 8]
                                          : wdata[7:0];
        end
    endgenerate

    assign load_data = lane_extend(bytes, addr_lo, mem_rdata);
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core load/store request into a single bus
// transaction and reports completion with a one-cycle done pulse.
//   clk, reset          - clock, synchronous active-high reset
//   en, funct, bytes    - request strobe, LOAD/STORE, access width
//   addr, wdata         - effective address, store data
//   rdata, stall, done, fault - load result, core hold, completion, error
//   mem_*               - simple request/ready bus, word addressed
// Optional feature: define LSU_TIMEOUT_EN to fault a bus access that sees
// neither mem_ready nor mem_err for TIMEOUT cycles.
module load_store_unit
    import LoadStoreUnitFuncts::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  LoadStoreUnitFuncts::Type funct,
    input  LoadStoreUnitBytes::Type  bytes,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     stall,
    output logic                     done,
    output logic                     fault,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_wstrb,
    input  logic                     mem_ready,
    input  logic                     mem_err,
    input  logic [31:0]              mem_rdata
);
    state_t                   state_reg, state_next;
    LoadStoreUnitFuncts::Type funct_reg;
    LoadStoreUnitBytes::Type  bytes_reg;
    logic [31:0]              addr_reg;
    logic [31:0]              wdata_reg;
    logic [31:0]              rdata_reg, rdata_next;
    logic                     fault_reg, fault_next;

    logic [3:0]               wstrb_raw;
    logic [31:0]              wdata_lanes;
    logic [31:0]              load_data;
    logic                     misaligned_in;
    logic                     timeout_hit;

    assign misaligned_in = is_misaligned(bytes, addr[1:0]);

    lsu_align u_align (
        .bytes       (bytes_reg),
        .addr_lo     (addr_reg[1:0]),
        .wdata       (wdata_reg),
        .mem_rdata   (mem_rdata),
        .wstrb       (wstrb_raw),
        .wdata_lanes (wdata_lanes),
        .load_data   (load_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_reg;

    // Counts BUSY cycles already spent waiting; the TIMEOUT-th idle BUSY
    // cycle is the last one.
    assign timeout_hit = (state_reg == BUSY) && !mem_ready && !mem_err &&
                         (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || state_reg != BUSY)
            cnt_reg <= '0;
        else if (!mem_ready && !mem_err)
            cnt_reg <= cnt_reg + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Request latch and completion results
    always_ff @(posedge clk) begin
        if (reset) begin
            funct_reg <= LOAD;
            bytes_reg <= LoadStoreUnitBytes::BYTE;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            fault_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && en) begin
                funct_reg <= funct;
                bytes_reg <= bytes;
                addr_reg  <= addr;
                wdata_reg <= wdata;
            end
            rdata_reg <= rdata_next;
            fault_reg <= fault_next;
        end
    end

    // Next state; rdata/fault only change on entry to DONE so rdata holds
    // between completions.
    always_comb begin
        state_next = state_reg;
        rdata_next = rdata_reg;
        fault_next = fault_reg;
        unique case (state_reg)
            IDLE: begin
                if (en) begin
                    if (misaligned_in) begin
                        state_next = DONE;
                        rdata_next = '0;
                        fault_next = 1'b1;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                // Error takes priority over a simultaneous ready.
                if (mem_err) begin
                    state_next = DONE;
                    rdata_next = '0;
                    fault_next = 1'b1;
                end else if (mem_ready) begin
                    state_next = DONE;
                    rdata_next = (funct_reg == LOAD) ? load_data : 32'd0;
                    fault_next = 1'b0;
                end else if (timeout_hit) begin
                    state_next = DONE;
                    rdata_next = '0;
                    fault_next = 1'b1;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        mem_req   = (state_reg == BUSY);
        mem_we    = mem_req && (funct_reg == STORE);
        mem_addr  = mem_req ? {addr_reg[31:2], 2'b00} : 32'd0;
        mem_wdata = mem_we ? wdata_lanes : 32'd0;
        mem_wstrb = mem_we ? wstrb_raw : 4'd0;
        done      = (state_reg == DONE);
        fault     = done && fault_reg;
        rdata     = rdata_reg;
        stall     = en && !done;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a table of transactions, each
// pushing its expected completion to a scoreboard popped on done.
module tb_load_store_unit;
    import LoadStoreUnitFuncts::*;
    import LoadStoreUnitBytes::*;

    localparam int TIMEOUT_CYC = 4;
    localparam int NEVER       = 1000;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     en;
    LoadStoreUnitFuncts::Type funct;
    LoadStoreUnitBytes::Type  bytes;
    logic [31:0]              addr;
    logic [31:0]              wdata;
    logic [31:0]              rdata;
    logic                     stall;
    logic                     done;
    logic                     fault;
    logic                     mem_req;
    logic                     mem_we;
    logic [31:0]              mem_addr;
    logic [31:0]              mem_wdata;
    logic [3:0]               mem_wstrb;
    logic                     mem_ready;
    logic                     mem_err;
    logic [31:0]              mem_rdata;

    load_store_unit #(.TIMEOUT(TIMEOUT_CYC)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .funct     (funct),
        .bytes     (bytes),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .done      (done),
        .fault     (fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_err   (mem_err),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        fault;
        int          latency;
        int          reqs;
    } exp_t;

    exp_t sb[$];
    int   vec_count        = 0;
    int   miscompare_count = 0;

    task automatic check_eq(input string tag, input logic [31:0] actual,
                            input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompare_count++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drives one request starting just after a rising edge; responds on the
    // bus after 'delay' request cycles; checks bus fields every request cycle.
    task automatic run_txn(input string name,
                           input LoadStoreUnitFuncts::Type f,
                           input LoadStoreUnitBytes::Type b,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] word, input int delay,
                           input logic err, input logic drop_en,
                           input logic [31:0] exp_rdata, input logic exp_fault,
                           input int exp_lat, input int exp_reqs,
                           input logic [31:0] exp_maddr, input logic [3:0] exp_wstrb,
                           input logic [31:0] exp_mwdata);
        exp_t e;
        int   cyc       = 0;
        int   req_cyc   = 0;
        bit   got_done  = 0;
        e.name    = name;
        e.rdata   = exp_rdata;
        e.fault   = exp_fault;
        e.latency = exp_lat;
        e.reqs    = exp_reqs;
        sb.push_back(e);

        funct = f; bytes = b; addr = a; wdata = wd; en = 1'b1;
        while (!got_done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            mem_ready = 1'b0;
            mem_err   = 1'b0;
            if (done) begin
                got_done = 1;
                check_eq({name, "_stall_at_done"}, {31'd0, stall}, 32'd0);
                check_eq({name, "_req_at_done"}, {31'd0, mem_req}, 32'd0);
                if (sb.size() == 0) begin
                    check_eq({name, "_sb_empty"}, 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq({e.name, "_rdata"}, rdata, e.rdata);
                    check_eq({e.name, "_fault"}, {31'd0, fault}, {31'd0, e.fault});
                    check_eq({e.name, "_latency"}, cyc, e.latency);
                    check_eq({e.name, "_req_cycles"}, req_cyc, e.reqs);
                    $display("txn %s: rdata=0x%08h fault=%0d latency=%0d req_cycles=%0d",
                             e.name, rdata, fault, cyc, req_cyc);
                end
                en = 1'b0;
            end else begin
                check_eq({name, "_stall"}, {31'd0, stall}, {31'd0, en});
                if (mem_req) begin
                    req_cyc++;
                    check_eq({name, "_maddr"}, mem_addr, exp_maddr);
                    check_eq({name, "_we"}, {31'd0, mem_we}, {31'd0, f == STORE});
                    check_eq({name, "_wstrb"}, {28'd0, mem_wstrb}, {28'd0, exp_wstrb});
                    if (f == STORE)
                        check_eq({name, "_mwdata"}, mem_wdata, exp_mwdata);
                    if (req_cyc > delay) begin
                        mem_ready = 1'b1;
                        mem_err   = err;
                        mem_rdata = word;
                    end
                end
                if (drop_en && req_cyc == 1)
                    en = 1'b0;
            end
        end
        if (!got_done) begin
            check_eq({name, "_done_seen"}, 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            en = 1'b0;
        end
        // One cycle later: done must have dropped and rdata must hold.
        @(negedge clk);
        mem_ready = 1'b0;
        mem_err   = 1'b0;
        check_eq({name, "_done_pulse"}, {31'd0, done}, 32'd0);
        check_eq({name, "_rdata_hold"}, rdata, exp_rdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 1'b0; funct = LOAD; bytes = BYTE; addr = '0; wdata = '0;
        mem_ready = 1'b0; mem_err = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_fault", {31'd0, fault}, 32'd0);
        check_eq("rst_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check_eq("rst_maddr", mem_addr, 32'd0);
        check_eq("rst_mwdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        //      name            f      b       addr          wdata         word          dly   err  drop  exp_rdata     flt lat reqs maddr         wstrb    mwdata
        run_txn("ld_byte_neg",  LOAD,  BYTE,   32'h0000_0103, 32'h0,        32'h80FF_1234, 0,   0, 0, 32'hFFFF_FF80, 0, 3, 1, 32'h0000_0100, 4'b0000, 32'h0);
        run_txn("st_half",      STORE, HALF,   32'h0000_0202, 32'hDEAD_BEEF, 32'h0,        0,   0, 0, 32'h0000_0000, 0, 3, 1, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF);
        run_txn("ld_word_mis",  LOAD,  WORD,   32'h0000_0301, 32'h0,        32'h0,         0,   0, 0, 32'h0000_0000, 1, 2, 0, 32'h0,         4'b0000, 32'h0);
        run_txn("ld_halfu_dly", LOAD,  HALF_U, 32'h0000_0002, 32'h0,        32'hF00D_0000, 5,   0, 0, 32'h0000_F00D, 0, 8, 6, 32'h0000_0000, 4'b0000, 32'h0);
        run_txn("ld_half_neg",  LOAD,  HALF,   32'h0000_0002, 32'h0,        32'hF00D_0000, 0,   0, 0, 32'hFFFF_F00D, 0, 3, 1, 32'h0000_0000, 4'b0000, 32'h0);
        run_txn("ld_byteu",     LOAD,  BYTE_U, 32'h0000_0101, 32'h0,        32'h1234_5678, 0,   0, 0, 32'h0000_0056, 0, 3, 1, 32'h0000_0100, 4'b0000, 32'h0);
        run_txn("st_byte",      STORE, BYTE,   32'h0000_0001, 32'h1234_56A5, 32'h0,        1,   0, 0, 32'h0000_0000, 0, 4, 2, 32'h0000_0000, 4'b0010, 32'hA5A5_A5A5);
        run_txn("ld_word",      LOAD,  WORD,   32'h0000_0020, 32'h0,        32'h8765_4321, 0,   0, 0, 32'h8765_4321, 0, 3, 1, 32'h0000_0020, 4'b0000, 32'h0);
        run_txn("st_word",      STORE, WORD,   32'h0000_0010, 32'hCAFE_F00D, 32'h0,        0,   0, 0, 32'h0000_0000, 0, 3, 1, 32'h0000_0010, 4'b1111, 32'hCAFE_F00D);
        run_txn("ld_err_rdy",   LOAD,  WORD,   32'h0000_0030, 32'h0,        32'hFFFF_FFFF, 0,   1, 0, 32'h0000_0000, 1, 3, 1, 32'h0000_0030, 4'b0000, 32'h0);
        run_txn("ld_half_mis",  LOAD,  HALF,   32'h0000_0003, 32'h0,        32'h0,         0,   0, 0, 32'h0000_0000, 1, 2, 0, 32'h0,         4'b0000, 32'h0);
        run_txn("ld_en_drop",   LOAD,  BYTE,   32'h0000_0000, 32'h0,        32'h0000_007F, 2,   0, 1, 32'h0000_007F, 0, 5, 3, 32'h0000_0000, 4'b0000, 32'h0);
        run_txn("st_half_mis",  STORE, HALF,   32'h0000_0001, 32'h1111_2222, 32'h0,        0,   0, 0, 32'h0000_0000, 1, 2, 0, 32'h0,         4'b0000, 32'h0);
`ifdef LSU_TIMEOUT_EN
        run_txn("ld_timeout",   LOAD,  WORD,   32'h0000_0040, 32'h0,        32'h0,     NEVER,   0, 0, 32'h0000_0000, 1, 2 + TIMEOUT_CYC, TIMEOUT_CYC, 32'h0000_0040, 4'b0000, 32'h0);
`endif
        run_txn("ld_pre_rst",   LOAD,  WORD,   32'h0000_0050, 32'h0,        32'h5A5A_0001, 0,   0, 0, 32'h5A5A_0001, 0, 3, 1, 32'h0000_0050, 4'b0000, 32'h0);

        // Reset in the middle of a bus access; a late ready must be ignored.
        funct = LOAD; bytes = WORD; addr = 32'h0000_0400; en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rstbusy_req_before", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        en    = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_2222;
        check_eq("rstbusy_req_after", {31'd0, mem_req}, 32'd0);
        check_eq("rstbusy_maddr", mem_addr, 32'd0);
        check_eq("rstbusy_rdata", rdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rstbusy_no_req", {31'd0, mem_req}, 32'd0);
            check_eq("rstbusy_no_done", {31'd0, done}, 32'd0);
        end
        mem_ready = 1'b0;
        $display("txn rst_mid_busy: late ready ignored, rdata=0x%08h", rdata);
        check_eq("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 255: bus wait cycles before a timeout fault (used only with LSU_TIMEOUT_EN).
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 en  input  1  MicroCode ld_st_unit.en; access requested this instruction.
REQ-005 funct  input  LoadStoreUnitFuncts::Type  LOAD or STORE.
REQ-006 bytes  input  LoadStoreUnitBytes::Type  BYTE, HALF, WORD, BYTE_U, HALF_U.
REQ-007 addr  input  32  effective address (ALU result).
REQ-008 wdata  input  32  store data (rs2).
REQ-009 rdata  output  32  load result, extended, to RdSrc::LD mux.
REQ-010 stall  output  1  hold PC/regfile; equals en AND NOT done.
REQ-011 done  output  1  one-cycle completion pulse; core commits this cycle.
REQ-012 fault  output  1  valid with done; misaligned or bus error/timeout.
REQ-013 mem_req / mem_we  output  1 each  bus request / write.
REQ-014 mem_addr  output  32  word address, bits[1:0]=0.
REQ-015 mem_wdata  output  32  lane-shifted store data; mem_wstrb  output  4  byte enables.
REQ-016 mem_ready / mem_err  input  1 each  bus accept+complete / error, sampled only while mem_req=1.
REQ-017 mem_rdata  input  32  read word, valid when mem_ready=1.

Function
REQ-018 FSM states IDLE, BUSY, DONE SHALL be the only states.
REQ-019 IDLE: en=1 and aligned -> BUSY next cycle, latching funct, bytes, addr, wdata; en=1 and misaligned -> DONE with fault=1, no bus access; en=0 -> stay.
REQ-020 Misaligned: HALF/HALF_U with addr[0]=1; WORD with addr[1:0]!=0; BYTE never misaligned.
REQ-021 BUSY: mem_req=1 with mem_addr, mem_we, mem_wdata, mem_wstrb stable from latched values until mem_ready=1 or mem_err=1; then -> DONE.
REQ-022 mem_wstrb: BYTE 4'b0001<<addr[1:0]; HALF 4'b0011<<addr[1:0]; WORD 4'b1111; mem_wstrb=0 when mem_we=0.
REQ-023 mem_wdata: wdata low byte/halfword replicated to all lanes; WORD unchanged.
REQ-024 Load data captured on the mem_ready cycle, lane selected by addr[1:0]; BYTE/HALF sign-extended, BYTE_U/HALF_U zero-extended, WORD raw.
REQ-025 DONE: done=1 for exactly one cycle, rdata valid (0 for STORE or fault), fault valid; -> IDLE next cycle.
REQ-026 Minimum latency: en cycle + BUSY(1 with mem_ready immediate) + DONE = done on the 3rd cycle after en first seen.
REQ-027 en dropping during BUSY SHALL NOT abort the bus transaction; completion proceeds, done still pulses.
REQ-028 mem_err=1 with mem_ready=1 in the same cycle: error wins, fault=1, rdata=0.
REQ-029 rdata holds its DONE value until the next DONE.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE and, from the next cycle, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, rdata=0, done=0, fault=0, timeout counter=0.
REQ-031 Reset mid-BUSY abandons the transaction; a late mem_ready after reset SHALL be ignored.

Configuration
REQ-032 Macro LSU_TIMEOUT_EN defined: counter increments each BUSY cycle without ready/err; reaching TIMEOUT -> DONE, fault=1, mem_req dropped.
REQ-033 Macro LSU_TIMEOUT_EN undefined: no counter, BUSY waits indefinitely.

Structure
REQ-034 FSM state enum and lane-extract/extend function SHALL live in shared package LoadStoreUnitFuncts alongside Type and LoadStoreUnitBytes.
REQ-035 One sub-module, lsu_align (combinational strobe/shift/extend), SHALL be instantiated; FSM stays in load_store_unit.

Verification
REQ-036 LOAD BYTE addr=0x103, mem_rdata=0x80FF_1234, mem_ready immediate -> mem_addr=0x100, rdata=0xFFFF_FF80, done on 3rd cycle, fault=0.
REQ-037 STORE HALF addr=0x202, wdata=0xDEAD_BEEF -> mem_wstrb=4'b1100, mem_wdata=0xBEEF_BEEF, mem_we=1.
REQ-038 LOAD WORD addr=0x301 -> no mem_req ever, done+fault=1 on 2nd cycle, rdata=0.
REQ-039 LOAD HALF_U addr=0x002, mem_ready delayed 5 cycles, mem_rdata=0xF00D_0000 -> request signals stable 5 cycles, stall=1 throughout, rdata=0x0000_F00D.
REQ-040 With LSU_TIMEOUT_EN, TIMEOUT=4, mem_ready never -> fault=1 after 4 BUSY cycles, mem_req=0 next cycle.
REQ-041 reset pulsed during BUSY, then mem_ready=1 -> mem_req=0 after reset, no done pulse.
